// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
package ifq_pkg;

    localparam int          INSTR_W = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } ifq_state_e;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

endpackage

// File: rtl/ifetch_prefetch_queue_if.sv
// Instruction-memory request/ack bus and decode valid/ready bus of the fetch front end.
interface ifetch_prefetch_queue_if;
    import ifq_pkg::*;

    logic               mem_req_o;
    logic [31:0]        mem_addr_o;
    logic               mem_ack_i;
    logic [INSTR_W-1:0] mem_data_i;
    logic               instr_valid_o;
    logic [INSTR_W-1:0] instr_o;
    logic [31:0]        instr_pc_o;
    logic               instr_ready_i;

    modport master (
        output mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o,
        input  mem_ack_i, mem_data_i, instr_ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o,
        output mem_ack_i, mem_data_i, instr_ready_i
    );

endinterface

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of {pc, instr} entries; pointers carry an extra wrap bit for full/empty.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  entry_t                       i_data,
    output entry_t                       o_head,
    output logic                         o_empty,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    entry_t        r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_data;
                r_wptr                <= r_wptr + (AW+1)'(1);
            end
            if (i_pop) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    assign o_head  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_count = r_wptr - r_rptr;

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// Fetch front end: owns the fetch PC, issues one word request at a time, buffers words for decode.
// Optional macro IFQ_BYPASS_EN forwards an ack straight to decode when the queue is empty.
module ifetch_prefetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         redirect_i,
    input  logic [31:0]                  redirect_pc_i,
    ifetch_prefetch_queue_if.master      bus,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int         CW       = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_REQ   = REQ;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic          w_ack;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic          w_byp_take;
    logic          w_issue_nxt;
    logic [CW-1:0] w_cnt_nxt;
    entry_t        w_head;
    entry_t        w_push_ent;

    assign w_ack = (r_state == ST_REQ) && bus.mem_ack_i;

`ifdef IFQ_BYPASS_EN
    logic w_byp;
    assign w_byp             = w_ack && w_empty && !redirect_i;
    assign w_byp_take        = w_byp && bus.instr_ready_i;
    assign bus.instr_valid_o = !w_empty || w_byp;
    assign bus.instr_o       = w_byp ? bus.mem_data_i : w_head.instr;
    assign bus.instr_pc_o    = w_byp ? r_fetch_pc     : w_head.pc;
`else
    assign w_byp_take        = 1'b0;
    assign bus.instr_valid_o = !w_empty;
    assign bus.instr_o       = w_head.instr;
    assign bus.instr_pc_o    = w_head.pc;
`endif

    // Redirect discards both the returning word and any decode handshake in its cycle.
    assign w_push      = w_ack && !redirect_i && !w_byp_take;
    assign w_pop       = !w_empty && bus.instr_ready_i && !redirect_i;
    assign w_cnt_nxt   = count_o + CW'(w_push) - CW'(w_pop);
    assign w_issue_nxt = start_i && !redirect_i && (w_cnt_nxt < FULL_CNT);
    assign w_push_ent  = '{pc: r_fetch_pc, instr: bus.mem_data_i};

    assign bus.mem_req_o  = (r_state == ST_REQ);
    assign bus.mem_addr_o = r_fetch_pc;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start_i && !redirect_i && !w_full) w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (bus.mem_ack_i)   w_state_nxt = w_issue_nxt ? ST_REQ : ST_IDLE;
                else if (redirect_i) w_state_nxt = ST_DRAIN;
            end
            // An ack here closes the abandoned request even if another redirect lands with it.
            ST_DRAIN: if (bus.mem_ack_i) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_i)  r_fetch_pc <= redirect_pc_i & 32'hFFFF_FFFC;
            else if (w_ack)  r_fetch_pc <= r_fetch_pc + PC_STEP;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .i_data  (w_push_ent),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (count_o)
    );

endmodule

// File: doc/ifetch_prefetch_queue.md
Name: ifetch_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of decode/register read.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over valid/ready.
- Redirect (branch/jump) input flushes the queue and restarts fetch at a new PC.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  fetch enable; when low, no new request is issued (an in-flight request still completes).
- mem_req_o  out  1  request to instruction memory.
- mem_addr_o  out  32  word-aligned request address.
- mem_ack_i  in  1  memory completion; mem_data_i is valid this cycle.
- mem_data_i  in  32  returned instruction word.
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  32  new fetch PC; bits [1:0] ignored (forced 2'b00).
- instr_valid_o  out  1  queue head valid.
- instr_o  out  32  head instruction.
- instr_pc_o  out  32  PC of the head instruction.
- instr_ready_i  in  1  decode accepts the head this cycle.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset values: mem_req_o=0, mem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0, count_o=0, fetch_pc=RESET_PC, FSM=IDLE.
- FSM states: IDLE, REQ, DRAIN. At most one request is outstanding.
- IDLE -> REQ: when start_i=1, redirect_i=0 and count_o < DEPTH (the slot is reserved at issue). In REQ, mem_req_o=1 and mem_addr_o=fetch_pc, both held stable until ack.
- Same-cycle ack: the memory may assert mem_ack_i in the first cycle mem_req_o is high.
- REQ + ack:
  - Push {fetch_pc, mem_data_i}; fetch_pc += 4 (wraps modulo 2^32).
  - Go to REQ again if the issue condition still holds using the post-push count; otherwise go to IDLE.
  - Back-to-back requests give one word per cycle with a zero-wait memory.
- Pop: occurs when instr_valid_o && instr_ready_i. instr_o and instr_pc_o are registered from the FIFO head.
- Push and pop in the same cycle: count unchanged. Push never occurs when full, because slot reservation guarantees space.
- Redirect (highest priority, any state):
  - FIFO cleared (count_o=0, instr_valid_o=0 next cycle).
  - fetch_pc <= {redirect_pc_i[31:2], 2'b00}.
  - Any pop or push in that cycle is discarded.
  - If in REQ without ack this cycle: go to DRAIN, drop mem_req_o, and discard the next ack's data. DRAIN -> IDLE on ack.
  - If ack arrives in the redirect cycle: data dropped, go to IDLE.
  - Redirect while in DRAIN: update fetch_pc, remain in DRAIN.
- Issue latency: first instruction visible on instr_valid_o one cycle after the ack cycle.
- start_i low mid-request: the request completes and its word is pushed; no further issue.
- Reset asserted mid-request: all state returns to reset values immediately. The memory is required to abandon its transaction on the same reset.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined: when the FIFO is empty and an ack arrives, mem_data_i and fetch_pc drive instr_o/instr_pc_o combinationally with instr_valid_o=1 in the ack cycle. If instr_ready_i=1, the word is consumed without being written; otherwise it is pushed normally.
- Undefined: fully registered outputs; minimum 1-cycle ack-to-valid latency.

Decomposition:
- Shared package ifq_pkg holds:
  - FSM state enum {IDLE, REQ, DRAIN}.
  - INSTR_W=32, PC_STEP=4.
  - Entry struct {pc, instr}.
- Natural sub-module: ifq_fifo, a synchronous FIFO of DEPTH entries with push/pop/flush and count, wrap-around pointers with an extra MSB for full/empty.

Test Plan:
- Reset, start_i=1, zero-wait memory: mem_addr_o issues 0x0, 0x4, 0x8, 0xC on consecutive cycles; decode with ready=1 sees instr_pc_o=0x0 one cycle after the first ack.
- instr_ready_i=0, memory acks immediately: count_o reaches 4, mem_req_o deasserts, and no 5th request is issued. One pop -> exactly one new request at 0x10.
- 3-cycle memory latency, redirect_i=1 with redirect_pc_i=0x103 in the middle of the request: FSM enters DRAIN, the late ack's data is not pushed, the next request address is 0x100, and the queue is empty.
- Redirect in the same cycle as an ack and a pop with count 2: count_o=0 next cycle, instr_valid_o=0, and neither the acked word nor the pop takes effect.
- fetch_pc=0xFFFF_FFFC, then ack: next request address is 0x0000_0000.
- rst_i pulled low for 1 cycle while mem_req_o=1: outputs return to reset values asynchronously, and fetch restarts at RESET_PC.
